// File: rtl/npc_svm_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : npc_pkg
//  Description : Shared types and constants for the NPC SVM sequencer:
//                state-code geometry, the vector-set record and helpers for
//                set validation and segment selection.
//  Revision    : 1.0 - initial release
// ============================================================================
package npc_pkg;

    localparam int NPC_STATE_W    = 5;
    localparam int NPC_NUM_STATES = 27;
    localparam int NPC_SAFE_STATE = 13;
    localparam int NPC_CNT_W      = 16;
    localparam int NPC_NUM_SEGS   = 4;

    // One complete vector set: carrier peak, three thresholds, four codes.
    typedef struct packed {
        logic [NPC_CNT_W-1:0]                      period;
        logic [NPC_CNT_W-1:0]                      t0;
        logic [NPC_CNT_W-1:0]                      t1;
        logic [NPC_CNT_W-1:0]                      t2;
        logic [NPC_NUM_SEGS-1:0][NPC_STATE_W-1:0]  s;
    } svm_set_t;

    // A set is usable only with a non-zero peak, monotonic thresholds that
    // stay within the peak, and every code inside the legal 0..26 range.
    function automatic logic set_is_valid(input svm_set_t x);
        logic ok;
        ok = (x.period != '0) && (x.t0 <= x.t1) && (x.t1 <= x.t2) &&
             (x.t2 <= x.period);
        for (int i = 0; i < NPC_NUM_SEGS; i++) begin
            if (x.s[i] > NPC_STATE_W'(NPC_NUM_STATES - 1)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Highest threshold reached wins, so equal thresholds collapse the
    // segments between them and those codes are never emitted.
    function automatic logic [1:0] seg_select(input logic [NPC_CNT_W-1:0] cnt,
                                              input svm_set_t            x);
        if (cnt >= x.t2)      return 2'd3;
        else if (cnt >= x.t1) return 2'd2;
        else if (cnt >= x.t0) return 2'd1;
        else                  return 2'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/npc_svm_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : npc_svm_sequencer_if
//  Description : Command port of the SVM sequencer (valid/ready vector-set
//                transfer plus the invalid-command pulse).
//  Ports       : cmd_valid/cmd_ready handshake, cmd_period, cmd_t0..t2,
//                cmd_s0..s3 payload, cmd_err status.
//                master = command source, slave = sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface npc_svm_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_period;
    logic [CNT_W-1:0] cmd_t0;
    logic [CNT_W-1:0] cmd_t1;
    logic [CNT_W-1:0] cmd_t2;
    logic [4:0]       cmd_s0;
    logic [4:0]       cmd_s1;
    logic [4:0]       cmd_s2;
    logic [4:0]       cmd_s3;
    logic             cmd_err;

    modport master (
        output cmd_valid, cmd_period, cmd_t0, cmd_t1, cmd_t2,
               cmd_s0, cmd_s1, cmd_s2, cmd_s3,
        input  cmd_ready, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_period, cmd_t0, cmd_t1, cmd_t2,
               cmd_s0, cmd_s1, cmd_s2, cmd_s3,
        output cmd_ready, cmd_err
    );
endinterface
`default_nettype wire

// File: rtl/npc_updown_carrier.sv
`default_nettype none
// ============================================================================
//  Module      : npc_updown_carrier
//  Description : Symmetric up/down carrier 0..P..1,0,... with period start
//                pulse. While run is low the counter is held at 0 counting up.
//  Ports       : clk, rst (async, active high), run (enable; low = load 0),
//                period (peak P), cnt, dir (1 = up), sync (leaving zero up).
//  Revision    : 1.0 - initial release
// ============================================================================
module npc_updown_carrier #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             run,
    input  wire logic [CNT_W-1:0] period,
    output logic      [CNT_W-1:0] cnt,
    output logic                  dir,
    output logic                  sync
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;

    // dir holds the direction of the next step: it turns down on reaching
    // the peak and up on reaching zero, so the count never exceeds P.
    always_comb begin
        cnt_d = '0;
        dir_d = 1'b1;
        if (run) begin
            cnt_d = dir_q ? (cnt_q + CNT_W'(1)) : (cnt_q - CNT_W'(1));
            if (cnt_d == period)  dir_d = 1'b0;
            else if (cnt_d == '0) dir_d = 1'b1;
            else                  dir_d = dir_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            dir_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    assign cnt  = cnt_q;
    assign dir  = dir_q;
    assign sync = run && (cnt_q == '0) && dir_q;

endmodule
`default_nettype wire

// File: rtl/npc_svm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : npc_svm_sequencer
//  Description : Plays back a 4-segment symmetric SVM vector sequence on an
//                up/down carrier; vector sets are double-buffered and swapped
//                in at carrier zero.
//  Ports       : clk, rst (async, active high), en (run enable),
//                cmd_if (slave command port), state (registered 5-bit code),
//                sync (period start pulse), cnt_dir (1 = counting up).
//  Revision    : 1.0 - initial release
// ============================================================================
module npc_svm_sequencer
    import npc_pkg::*;
#(
    parameter int                     CNT_W      = NPC_CNT_W,
    parameter logic [NPC_STATE_W-1:0] SAFE_STATE = NPC_STATE_W'(NPC_SAFE_STATE)
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    en,
    npc_svm_sequencer_if.slave           cmd_if,
    output logic [NPC_STATE_W-1:0]       state,
    output logic                         sync,
    output logic                         cnt_dir
);

    svm_set_t   act_q, act_d, pend_q, pend_d;
    logic       act_valid_q, act_valid_d;
    logic       pend_valid_q, pend_valid_d;
    logic       err_q, err_d;
    logic [NPC_STATE_W-1:0] state_q, state_d;

    svm_set_t   cmd_set, cur_set;
    logic       accept, cmd_ok, swap, cur_valid, run;
    logic [CNT_W-1:0] cnt;
    logic       dir;

    npc_updown_carrier #(.CNT_W(CNT_W)) u_carrier (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .period (cur_set.period),
        .cnt    (cnt),
        .dir    (dir),
        .sync   (sync)
    );

    always_comb begin
        cmd_set.period = cmd_if.cmd_period;
        cmd_set.t0     = cmd_if.cmd_t0;
        cmd_set.t1     = cmd_if.cmd_t1;
        cmd_set.t2     = cmd_if.cmd_t2;
        cmd_set.s[0]   = cmd_if.cmd_s0;
        cmd_set.s[1]   = cmd_if.cmd_s1;
        cmd_set.s[2]   = cmd_if.cmd_s2;
        cmd_set.s[3]   = cmd_if.cmd_s3;

        accept = cmd_if.cmd_valid && !pend_valid_q;
        cmd_ok = set_is_valid(cmd_set);

        // The swapped-in set already drives the swap cycle itself, so its
        // codes start exactly at the period start (cnt == 0).
        swap      = pend_valid_q && (!act_valid_q || (en && cnt == '0 && dir));
        cur_set   = swap ? pend_q : act_q;
        cur_valid = act_valid_q || swap;
        run       = en && cur_valid;

        act_d        = cur_set;
        act_valid_d  = cur_valid;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q && !swap;
        if (accept && cmd_ok) begin
            pend_d       = cmd_set;
            pend_valid_d = 1'b1;
        end
        err_d = accept && !cmd_ok;

        state_d = run ? cur_set.s[seg_select(cnt, cur_set)] : SAFE_STATE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q        <= '0;
            act_valid_q  <= 1'b0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            err_q        <= 1'b0;
            state_q      <= SAFE_STATE;
        end else begin
            act_q        <= act_d;
            act_valid_q  <= act_valid_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            err_q        <= err_d;
            state_q      <= state_d;
        end
    end

    assign cmd_if.cmd_ready = !pend_valid_q;
    assign cmd_if.cmd_err   = err_q;
    assign state            = state_q;
    assign cnt_dir          = dir;

endmodule
`default_nettype wire

// File: tb/tb_npc_svm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_npc_svm_sequencer
//  Description : Self-checking bench for npc_svm_sequencer. A phase-based
//                reference model (carrier phase k in 0..2P-1) predicts state,
//                sync, cnt_dir, cmd_ready and cmd_err every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_svm_sequencer;

    logic       clk;
    logic       rst;
    logic       en;
    logic [4:0] state;
    logic       sync;
    logic       cnt_dir;

    npc_svm_sequencer_if #(.CNT_W(16)) cmd_if ();

    npc_svm_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cmd_if  (cmd_if),
        .state   (state),
        .sync    (sync),
        .cnt_dir (cnt_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int p;
        int t0;
        int t1;
        int t2;
        int s[4];
    } mset_t;

    int    errors = 0;
    int    checks = 0;

    // Reference model state
    bit    m_av, m_pv;
    mset_t m_act, m_pend;
    int    m_k;
    int    m_state;
    int    m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_ok(input mset_t c);
        bit ok;
        ok = (c.p != 0) && (c.t0 <= c.t1) && (c.t1 <= c.t2) && (c.t2 <= c.p);
        for (int i = 0; i < 4; i++) if (c.s[i] > 26) ok = 0;
        return ok;
    endfunction

    function automatic int m_seg(input mset_t c, input int cnt);
        if (cnt >= c.t2) return 3;
        if (cnt >= c.t1) return 2;
        if (cnt >= c.t0) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_av    = 0;
        m_pv    = 0;
        m_k     = 0;
        m_state = 13;
        m_err   = 0;
    endtask

    task automatic set_cmd(input int p, input int t0, input int t1, input int t2,
                           input int s0, input int s1, input int s2, input int s3);
        cmd_if.cmd_period = 16'(p);
        cmd_if.cmd_t0     = 16'(t0);
        cmd_if.cmd_t1     = 16'(t1);
        cmd_if.cmd_t2     = 16'(t2);
        cmd_if.cmd_s0     = 5'(s0);
        cmd_if.cmd_s1     = 5'(s1);
        cmd_if.cmd_s2     = 5'(s2);
        cmd_if.cmd_s3     = 5'(s3);
    endtask

    // Called just after a falling edge; checks current outputs, then advances
    // the model across the coming rising edge and returns at the next fall.
    task automatic step();
        mset_t cur, c;
        bit    rdy, swap, cv, run, acc;
        int    cnt;
        #1;
        rdy  = !m_pv;
        swap = m_pv && (!m_av || (en && m_k == 0));
        cur  = swap ? m_pend : m_act;
        cv   = m_av || swap;
        run  = en && cv;

        chk("state",     32'(state),            32'(m_state));
        chk("cmd_err",   32'(cmd_if.cmd_err),   32'(m_err));
        chk("cmd_ready", 32'(cmd_if.cmd_ready), 32'(rdy));
        chk("sync",      32'(sync),             32'(run && m_k == 0));
        chk("cnt_dir",   32'(cnt_dir),          (!cv || m_k < cur.p) ? 32'd1 : 32'd0);

        c.p  = int'(cmd_if.cmd_period); c.t0 = int'(cmd_if.cmd_t0);
        c.t1 = int'(cmd_if.cmd_t1);     c.t2 = int'(cmd_if.cmd_t2);
        c.s[0] = int'(cmd_if.cmd_s0);   c.s[1] = int'(cmd_if.cmd_s1);
        c.s[2] = int'(cmd_if.cmd_s2);   c.s[3] = int'(cmd_if.cmd_s3);
        acc = cmd_if.cmd_valid && rdy;

        if (run) begin
            cnt     = (m_k <= cur.p) ? m_k : 2 * cur.p - m_k;
            m_state = cur.s[m_seg(cur, cnt)];
            m_k     = (m_k + 1) % (2 * cur.p);
        end else begin
            m_state = 13;
            m_k     = 0;
        end
        m_err = (acc && !m_ok(c)) ? 1 : 0;
        if (swap) m_pv = 0;
        m_act = cur;
        m_av  = cv;
        if (acc && m_ok(c)) begin
            m_pend = c;
            m_pv   = 1;
        end
        @(negedge clk);
    endtask

    task automatic send(input int p, input int t0, input int t1, input int t2,
                        input int s0, input int s1, input int s2, input int s3);
        int n;
        set_cmd(p, t0, t1, t2, s0, s1, s2, s3);
        cmd_if.cmd_valid = 1'b1;
        n = 0;
        while (m_pv && n < 200) begin
            step();
            n++;
        end
        chk("send_timeout", 32'(m_pv), 32'd0);
        step();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic rand_cmd();
        int p, v[3], tmp, kind;
        p = $urandom_range(1, 12);
        for (int i = 0; i < 3; i++) v[i] = $urandom_range(0, p);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2 - i; j++)
                if (v[j] > v[j+1]) begin tmp = v[j]; v[j] = v[j+1]; v[j+1] = tmp; end
        set_cmd(p, v[0], v[1], v[2], $urandom_range(0, 26), $urandom_range(0, 26),
                $urandom_range(0, 26), $urandom_range(0, 26));
        kind = $urandom_range(0, 7);
        if (kind == 0) cmd_if.cmd_s2     = 5'($urandom_range(27, 31));
        if (kind == 1) cmd_if.cmd_t1     = cmd_if.cmd_t2 + 16'd1;
        if (kind == 2) cmd_if.cmd_period = 16'd0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        en  = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        set_cmd(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) step();

        // Basic sequence P=10, thresholds 2/5/8, codes 1..4
        en = 1'b1;
        send(10, 2, 5, 8, 1, 2, 3, 4);
        repeat (44) step();

        // New set accepted mid-period: held pending until the next period start
        repeat (7) step();
        send(6, 1, 3, 5, 5, 6, 7, 8);
        repeat (30) step();

        // Invalid commands: bad code, unordered thresholds, zero peak
        send(6, 1, 3, 5, 5, 6, 27, 8);  repeat (3) step();
        send(6, 1, 4, 3, 5, 6, 7, 8);   repeat (3) step();
        send(0, 0, 0, 0, 5, 6, 7, 8);   repeat (3) step();

        // Degenerate thresholds
        send(5, 0, 0, 0, 1, 2, 3, 26);  repeat (25) step();
        send(5, 6, 6, 6, 1, 2, 3, 26);  repeat (3) step();
        send(5, 5, 5, 5, 0, 0, 0, 26);  repeat (25) step();

        // Enable drop on the down slope, then resume
        send(10, 2, 5, 8, 1, 2, 3, 4);
        n = 0;
        while (!(m_av && m_act.p == 10 && m_k > 12) && n < 100) begin
            step();
            n++;
        end
        chk("down_slope_timeout", 32'(n < 100), 32'd1);
        en = 1'b0;
        repeat (4) step();
        en = 1'b1;
        repeat (25) step();

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(state),            32'd13);
        chk("async_rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        chk("async_rst_sync",  32'(sync),             32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) step();
        send(4, 1, 2, 3, 9, 10, 11, 12);
        repeat (20) step();

        // Randomized traffic
        repeat (600) begin
            en = ($urandom_range(0, 19) != 0);
            cmd_if.cmd_valid = ($urandom_range(0, 7) == 0);
            rand_cmd();
            step();
        end
        cmd_if.cmd_valid = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
